control_juego: RTL
==================

CONTROL_JUEGO -- requirements
Module: control_juego

Interface
REQ-001 SHALL have parameter SEMILLA, default 16'hACE1, LFSR reset seed (nonzero).
REQ-002 SHALL have parameter MAX_MOV, default 65535, saturation value of contador_mov.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port btn_valid  input  1  one-cycle move request strobe.
REQ-006 SHALL have port btn_dir  input  3  move code: 1 left, 2 right, 3 up, 4 down; others invalid.
REQ-007 SHALL have port mov_matriz  input  int[4][4]  board from movement datapath for mov_selector.
REQ-008 SHALL have port mov_gano  input  1  datapath win flag for current selector.
REQ-009 SHALL have port mov_perdio  input  1  datapath no-move-possible flag.
REQ-010 SHALL have port mov_selector  output  3  selector driven to movement datapath.
REQ-011 SHALL have port matriz_juego  output  int[4][4]  registered game board, feeds datapath input.
REQ-012 SHALL have port contador_mov  output  16  count of effective moves.
REQ-013 SHALL have port estado  output  3  current FSM state code.
REQ-014 SHALL have ports ocupado, gano, perdio  output  1 each  busy / won / lost flags.

Function
REQ-015 SHALL implement FSM states INICIO=0, ESPERA=1, MOVER=2, CAPTURA=3, GENERAR=4, VERIFICAR=5, GANO=6, PERDIO=7; estado = state code.
REQ-016 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11) advancing every cycle, reset to SEMILLA.
REQ-017 INICIO SHALL place two tiles via the spawn engine, then go to ESPERA.
REQ-018 ESPERA SHALL drive mov_selector=0; btn_valid with valid btn_dir latches direction and goes to MOVER next cycle; invalid codes ignored.
REQ-019 btn_valid outside ESPERA SHALL be ignored (no queueing).
REQ-020 MOVER SHALL drive mov_selector=latched direction for one cycle (settle), then CAPTURA with selector held.
REQ-021 CAPTURA: if mov_matriz equals matriz_juego, SHALL return to ESPERA unchanged with no counter increment; else SHALL register mov_matriz into matriz_juego, increment contador_mov (saturate at MAX_MOV), go to GENERAR.
REQ-022 Spawn engine: start index = lfsr[3:0]; examine one cell per cycle, index row*4+col, wrapping 15->0; first zero cell gets 4 if lfsr[7:4]==0 else 2.
REQ-023 If 16 cells examined with none empty, spawn SHALL abort without write: from GENERAR go to PERDIO; from INICIO proceed to ESPERA.
REQ-024 After successful spawn GENERAR SHALL go to VERIFICAR with mov_selector=0.
REQ-025 VERIFICAR SHALL sample mov_gano first: 1 -> GANO; else mov_perdio 1 -> PERDIO; else ESPERA.
REQ-026 gano SHALL be 1 exactly in GANO, perdio exactly in PERDIO; ocupado SHALL be 1 in INICIO, MOVER, CAPTURA, GENERAR, VERIFICAR.
REQ-027 Latency: btn_valid at edge N -> MOVER in N+1, CAPTURA N+2, board updated at edge N+3; spawn takes 1-16 cycles.
REQ-028 matriz_juego SHALL change only at CAPTURA update and spawn writes.

Reset
REQ-029 rst_n low SHALL immediately force: state INICIO, matriz_juego all 0, contador_mov 0, mov_selector 0, gano/perdio 0, lfsr SEMILLA, spawn engine idle; applies mid-move or mid-spawn.
REQ-030 After rst_n release, INICIO SHALL begin on the first clock edge.

Configuration
REQ-031 Macro REINICIO_EN defined: btn_valid (any btn_dir) in GANO or PERDIO SHALL clear board and contador_mov and go to INICIO next cycle.
REQ-032 REINICIO_EN undefined: GANO and PERDIO SHALL be terminal until rst_n asserted; btn_valid ignored.

Verification
REQ-033 Reset release, bench datapath tied to identity -> within 34 cycles estado=1, exactly two nonzero cells, each 2 or 4, contador_mov=0.
REQ-034 ESPERA, btn_valid dir=1, mov_matriz==matriz_juego -> estado 2,3,1 on consecutive cycles, board and contador_mov unchanged.
REQ-035 ESPERA, btn_valid dir=2, mov_matriz differs -> board=mov_matriz plus one new tile, contador_mov=1, back to ESPERA.
REQ-036 Move with mov_gano=1 in VERIFICAR -> estado=6, gano=1; btn_valid then: with REINICIO_EN estado=0 and board 0, without it estado stays 6.
REQ-037 Move yielding mov_matriz with all 16 cells nonzero -> spawn aborts after 16 cycles, estado=7, perdio=1.
REQ-038 rst_n pulsed low mid-GENERAR -> same cycle all outputs at reset values, estado=0.

Source files
------------

// File: rtl/control_juego.sv
// Game sequencer for a 4x4 sliding-tile board: move handshake with the datapath, move counter, LFSR tile spawner.
// Optional macro REINICIO_EN: a button press in GANO/PERDIO restarts the game instead of those states being terminal.
module control_juego #(
  parameter logic [15:0] SEMILLA = 16'hACE1,
  parameter int          MAX_MOV = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_valid,
  input  logic [2:0]  btn_dir,
  input  int          mov_matriz [4][4],
  input  logic        mov_gano,
  input  logic        mov_perdio,
  output logic [2:0]  mov_selector,
  output int          matriz_juego [4][4],
  output logic [15:0] contador_mov,
  output logic [2:0]  estado,
  output logic        ocupado,
  output logic        gano,
  output logic        perdio
);

  // state     | meaning
  // INICIO    | place the two opening tiles
  // ESPERA    | idle, selector 0, waiting for a valid move
  // MOVER     | selector = direction, datapath settling
  // CAPTURA   | compare datapath board, register it if it changed
  // GENERAR   | spawn engine scans for an empty cell
  // VERIFICAR | selector 0, sample win / no-move flags
  // GANO      | game won
  // PERDIO    | game lost
  typedef enum logic [2:0] {
    INICIO = 3'd0, ESPERA = 3'd1, MOVER = 3'd2, CAPTURA = 3'd3,
    GENERAR = 3'd4, VERIFICAR = 3'd5, GANO = 3'd6, PERDIO = 3'd7
  } t_estado;

  localparam logic [15:0] L_MAX = 16'(MAX_MOV);

  t_estado     r_estado;
  int          r_mat [4][4];
  logic [15:0] r_cont;
  logic [2:0]  r_sel;
  logic [15:0] r_lfsr;
  logic        r_sp_activo;
  logic [3:0]  r_sp_idx;
  logic [3:0]  r_sp_cnt;
  logic        r_sp_cuatro;
  logic        r_fichas;

  logic        w_iguales;
  logic        w_fb;
  int          w_celda;

  assign w_fb    = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_celda = r_mat[r_sp_idx[3:2]][r_sp_idx[1:0]];

  always_comb begin
    w_iguales = 1'b1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (mov_matriz[i][j] != r_mat[i][j]) w_iguales = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado    <= INICIO;
      r_cont      <= '0;
      r_sel       <= '0;
      r_lfsr      <= SEMILLA;
      r_sp_activo <= 1'b0;
      r_sp_idx    <= '0;
      r_sp_cnt    <= '0;
      r_sp_cuatro <= 1'b0;
      r_fichas    <= 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          r_mat[i][j] <= 0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
      case (r_estado)
        INICIO: begin
          if (!r_sp_activo) begin
            r_sp_activo <= 1'b1;
            r_sp_idx    <= r_lfsr[3:0];
            r_sp_cnt    <= '0;
            r_sp_cuatro <= (r_lfsr[7:4] == 4'd0);
          end else if (w_celda == 0) begin
            r_mat[r_sp_idx[3:2]][r_sp_idx[1:0]] <= r_sp_cuatro ? 4 : 2;
            if (r_fichas) begin
              r_sp_activo <= 1'b0;
              r_estado    <= ESPERA;
            end else begin
              // second tile restarts the scan from a fresh random position
              r_fichas    <= 1'b1;
              r_sp_idx    <= r_lfsr[3:0];
              r_sp_cnt    <= '0;
              r_sp_cuatro <= (r_lfsr[7:4] == 4'd0);
            end
          end else if (r_sp_cnt == 4'd15) begin
            r_sp_activo <= 1'b0;
            r_estado    <= ESPERA;
          end else begin
            r_sp_idx <= r_sp_idx + 4'd1;
            r_sp_cnt <= r_sp_cnt + 4'd1;
          end
        end
        ESPERA: begin
          r_sel <= '0;
          if (btn_valid && btn_dir >= 3'd1 && btn_dir <= 3'd4) begin
            r_sel    <= btn_dir;
            r_estado <= MOVER;
          end
        end
        MOVER: r_estado <= CAPTURA;
        CAPTURA: begin
          r_sel <= '0;
          if (w_iguales) begin
            r_estado <= ESPERA;
          end else begin
            r_mat <= mov_matriz;
            if (r_cont != L_MAX) r_cont <= r_cont + 16'd1;
            r_sp_activo <= 1'b1;
            r_sp_idx    <= r_lfsr[3:0];
            r_sp_cnt    <= '0;
            r_sp_cuatro <= (r_lfsr[7:4] == 4'd0);
            r_estado    <= GENERAR;
          end
        end
        GENERAR: begin
          if (w_celda == 0) begin
            r_mat[r_sp_idx[3:2]][r_sp_idx[1:0]] <= r_sp_cuatro ? 4 : 2;
            r_sp_activo <= 1'b0;
            r_estado    <= VERIFICAR;
          end else if (r_sp_cnt == 4'd15) begin
            r_sp_activo <= 1'b0;
            r_estado    <= PERDIO;
          end else begin
            r_sp_idx <= r_sp_idx + 4'd1;
            r_sp_cnt <= r_sp_cnt + 4'd1;
          end
        end
        VERIFICAR: begin
          if (mov_gano)        r_estado <= GANO;
          else if (mov_perdio) r_estado <= PERDIO;
          else                 r_estado <= ESPERA;
        end
        GANO, PERDIO: begin
`ifdef REINICIO_EN
          if (btn_valid) begin
            for (int i = 0; i < 4; i++)
              for (int j = 0; j < 4; j++)
                r_mat[i][j] <= 0;
            r_cont      <= '0;
            r_fichas    <= 1'b0;
            r_sp_activo <= 1'b0;
            r_estado    <= INICIO;
          end
`endif
        end
        default: r_estado <= INICIO;
      endcase
    end
  end

  assign mov_selector = r_sel;
  assign matriz_juego = r_mat;
  assign contador_mov = r_cont;
  assign estado       = r_estado;
  assign gano         = (r_estado == GANO);
  assign perdio       = (r_estado == PERDIO);
  assign ocupado      = (r_estado == INICIO) || (r_estado == MOVER) || (r_estado == CAPTURA) ||
                        (r_estado == GENERAR) || (r_estado == VERIFICAR);

endmodule
